// File: rtl/hs32_pkg.sv
// Shared definitions for the HS32 front end: reset vector, word size and
// the fetch sequencer states.
package hs32_pkg;

    localparam logic [31:0] HS32_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES    = 32'd4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/hs32_fifo.sv
// Synchronous FIFO with a registered head word. Push and pop may coincide at
// any occupancy; clear empties it in one edge.
module hs32_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign count = count_reg;
    assign dout  = head_reg;

    // A pop frees the slot a same-cycle push needs when the FIFO is full.
    assign pop_ok      = pop && !empty;
    assign push_ok     = push && (!full || pop_ok);
    assign rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
    assign count_next  = count_reg + CW'(push_ok) - CW'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(push_ok);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // The incoming word becomes the head only when nothing older remains.
            if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
                head_reg <= din;
            end else begin
                head_reg <= mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: one outstanding word read, prefetch FIFO towards
// decode, and flush/redirect from execute.
module hs32_fetch
    import hs32_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = HS32_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] addr,
    output logic        rd,
    input  logic        ack,
    input  logic [31:0] dtr,
    output logic [31:0] instd,
    output logic [31:0] pcd,
    output logic        ackd,
    input  logic        reqd,
    input  logic        flush,
    input  logic [31:0] newpc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_reg;
    logic [31:0]   pc_reg;
    logic [31:0]   addr_reg;
    logic          rd_reg;
    logic          drop_reg;

    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] occ;
    logic          issue;
    logic [63:0]   head;

    assign addr  = addr_reg;
    assign rd    = rd_reg;
    assign ackd  = !fifo_empty;
    assign pcd   = head[63:32];
    assign instd = head[31:0];

    assign pop  = ackd && reqd && !flush;
    assign push = (state_reg == WAIT) && ack && !drop_reg && !flush && (!fifo_full || pop);

    // Only issue when the returning word is guaranteed a slot.
    assign occ   = fifo_count - CW'(pop);
    assign issue = !flush && (occ < CW'(DEPTH));

    hs32_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   ({addr_reg, dtr}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            addr_reg  <= RESET_PC;
            rd_reg    <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flush) begin
                        pc_reg <= word_align(newpc);
                    end else if (issue) begin
                        rd_reg    <= 1'b1;
                        addr_reg  <= pc_reg;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        pc_reg <= word_align(newpc);
                        if (ack) begin
                            rd_reg    <= 1'b0;
                            drop_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            // Request cannot be withdrawn; its word is discarded on arrival.
                            drop_reg <= 1'b1;
                        end
                    end else if (ack) begin
                        rd_reg    <= 1'b0;
                        drop_reg  <= 1'b0;
                        state_reg <= IDLE;
                        if (!drop_reg) begin
                            pc_reg <= pc_reg + WORD_BYTES;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
